// File: rtl/sysid_verify_ctrl.sv
// rtl/sysid_verify_ctrl.sv - boot-time sysid check sequencer holding the system in reset until ID matches
// Optional timestamp check enabled by defining SYSID_VERIFY_TS_CHECK_EN.
module sysid_verify_ctrl #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1476641584,
  parameter int          MAX_RETRY   = 3,
  parameter int          RETRY_DELAY = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        sys_hold,
  output logic        id_ok,
  output logic        id_fail,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);

  typedef enum logic [2:0] {
    RD_ID = 3'd0,
    RD_TS = 3'd1,
    CHECK = 3'd2,
    WAIT  = 3'd3,
    PASS  = 3'd4,
    FAIL  = 3'd5
  } state_t;

`ifdef SYSID_VERIFY_TS_CHECK_EN
  localparam bit TS_CHECK = 1'b1;
`else
  localparam bit TS_CHECK = 1'b0;
`endif

  state_t      state;
  logic [31:0] id_reg;
  logic [31:0] ts_reg;
  logic [7:0]  retry_cnt;
  logic [15:0] delay_cnt;

  logic        match;
  logic        state_is_terminal;
  logic        restart;
  logic [31:0] status_word;
  logic        unused_writedata;

  assign match = (id_reg == EXPECTED_ID) && (!TS_CHECK || (ts_reg == EXPECTED_TS));
  assign state_is_terminal = (state == PASS) || (state == FAIL);
  assign restart = avs_write && (avs_address == 2'd3) && avs_writedata[0];
  assign status_word = {16'b0, retry_cnt, 5'b0, state_is_terminal, id_fail, id_ok};
  assign unused_writedata = &{1'b0, avs_writedata[31:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RD_ID;
      sysid_address <= 1'b0;
      sys_hold      <= 1'b1;
      id_ok         <= 1'b0;
      id_fail       <= 1'b0;
      id_reg        <= '0;
      ts_reg        <= '0;
      retry_cnt     <= '0;
      delay_cnt     <= '0;
    end else begin
      case (state)
        RD_ID: begin
          id_reg        <= sysid_readdata;
          sysid_address <= 1'b1;
          state         <= RD_TS;
        end
        RD_TS: begin
          ts_reg        <= sysid_readdata;
          sysid_address <= 1'b0;
          state         <= CHECK;
        end
        CHECK: begin
          if (match) begin
            state    <= PASS;
            sys_hold <= 1'b0;
            id_ok    <= 1'b1;
          end else if (retry_cnt == 8'(MAX_RETRY)) begin
            state   <= FAIL;
            id_fail <= 1'b1;
          end else begin
            retry_cnt <= retry_cnt + 8'd1;
            delay_cnt <= 16'(RETRY_DELAY - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (delay_cnt == 16'd0) begin
            state <= RD_ID;
          end else begin
            delay_cnt <= delay_cnt - 16'd1;
          end
        end
        PASS, FAIL: begin
          // Restart is only honoured once a verdict exists, so an in-flight attempt cannot be disturbed.
          if (restart) begin
            state     <= RD_ID;
            sys_hold  <= 1'b1;
            id_ok     <= 1'b0;
            id_fail   <= 1'b0;
            retry_cnt <= '0;
          end
        end
        default: state <= RD_ID;
      endcase
    end
  end

  // Read data reflects pre-edge values, so a read alongside a restart sees the old status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        2'd0:    avs_readdata <= id_reg;
        2'd1:    avs_readdata <= ts_reg;
        2'd2:    avs_readdata <= status_word;
        default: avs_readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// tb/tb_sysid_verify_ctrl.sv - self-checking bench for sysid_verify_ctrl
module tb_sysid_verify_ctrl;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1476641584;
  localparam int MAXR = 3;
  localparam int RD   = 16;
  localparam int ATT  = RD + 3;
`ifdef SYSID_VERIFY_TS_CHECK_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sysid_address;
  logic [31:0] sysid_readdata;
  logic        sys_hold, id_ok, id_fail;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;

  logic [31:0] att_id [0:MAXR];
  logic [31:0] cur_id = 32'd0;
  logic [31:0] cur_ts = EXP_TS;

  int errors = 0;
  int checks = 0;

  assign sysid_readdata = sysid_address ? cur_ts : cur_id;

  always #5 clock = ~clock;

  sysid_verify_ctrl #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .MAX_RETRY(MAXR), .RETRY_DELAY(RD)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .sysid_address(sysid_address), .sysid_readdata(sysid_readdata),
    .sys_hold(sys_hold), .id_ok(id_ok), .id_fail(id_fail),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata)
  );

  typedef struct {
    logic [31:0] id_first;
    logic [31:0] id_rest;
    logic [31:0] ts;
    bit          exp_pass;
    int          exp_dec;
    logic [31:0] exp_idreg;
    logic [31:0] exp_status;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " sys_hold"}, {31'b0, sys_hold}, 32'd1);
    chk({tag, " id_ok"}, {31'b0, id_ok}, 32'd0);
    chk({tag, " id_fail"}, {31'b0, id_fail}, 32'd0);
    chk({tag, " sysid_address"}, {31'b0, sysid_address}, 32'd0);
    chk({tag, " avs_readdata"}, avs_readdata, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("reset");
    cur_id = att_id[0];
    reset_n = 1'b1;
  endtask

  // Outcome from the rules: first attempt whose words match wins; otherwise fail after MAXR retries.
  task automatic model(output bit pass, output int dec, output int retry);
    pass = 1'b0;
    retry = MAXR;
    for (int k = 0; k <= MAXR; k++) begin
      if (!pass && att_id[k] == EXP_ID && (!TS_EN || cur_ts == EXP_TS)) begin
        pass = 1'b1;
        retry = k;
      end
    end
    dec = 3 + retry * ATT;
  endtask

  task automatic run(input bit pass, input int dec, input int restart_at, input int stop_n);
    int n = 0;
    int a;
    while (n < stop_n) begin
      a = n / ATT;
      cur_id = att_id[(a > MAXR) ? MAXR : a];
      if (n == restart_at) begin
        avs_write = 1'b1;
        avs_address = 2'd3;
        avs_writedata = 32'd1;
      end
      @(posedge clock);
      n++;
      @(negedge clock);
      avs_write = 1'b0;
      chk($sformatf("sys_hold@E%0d", n), {31'b0, sys_hold}, {31'b0, !(pass && n >= dec)});
      chk($sformatf("id_ok@E%0d", n), {31'b0, id_ok}, {31'b0, pass && n >= dec});
      chk($sformatf("id_fail@E%0d", n), {31'b0, id_fail}, {31'b0, !pass && n >= dec});
      chk($sformatf("sysid_address@E%0d", n), {31'b0, sysid_address},
          {31'b0, (n < dec) && ((n - 1) % ATT == 0)});
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_read = 1'b1;
    avs_address = a;
    @(posedge clock);
    @(negedge clock);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic check_status(input logic [31:0] exp_id, input logic [31:0] exp_ts,
                              input logic [31:0] exp_st);
    logic [31:0] d;
    rd(2'd0, d); chk("read id_reg", d, exp_id);
    rd(2'd1, d); chk("read ts_reg", d, exp_ts);
    rd(2'd2, d); chk("read status", d, exp_st);
    rd(2'd3, d); chk("read addr3", d, 32'd0);
  endtask

  vec_t vecs [4];

  initial begin
    bit          pass;
    int          dec, retry, fm;
    logic [31:0] d, r;

    vecs[0] = '{32'd0, 32'd0, EXP_TS, 1'b1, 3, 32'd0, 32'h0000_0005};
    vecs[1] = '{32'd5, 32'd5, EXP_TS, 1'b0, 60, 32'd5, 32'h0000_0306};
    vecs[2] = '{32'd5, 32'd0, EXP_TS, 1'b1, 22, 32'd0, 32'h0000_0105};
`ifdef SYSID_VERIFY_TS_CHECK_EN
    vecs[3] = '{32'd0, 32'd0, 32'd123, 1'b0, 60, 32'd0, 32'h0000_0306};
`else
    vecs[3] = '{32'd0, 32'd0, 32'd123, 1'b1, 3, 32'd0, 32'h0000_0005};
`endif

    for (int i = 0; i < 4; i++) begin
      att_id[0] = vecs[i].id_first;
      for (int k = 1; k <= MAXR; k++) att_id[k] = vecs[i].id_rest;
      cur_ts = vecs[i].ts;
      do_reset();
      run(vecs[i].exp_pass, vecs[i].exp_dec, -1, vecs[i].exp_dec + 2);
      check_status(vecs[i].exp_idreg, vecs[i].ts, vecs[i].exp_status);
    end

    for (int i = 0; i < 6; i++) begin
      fm = $urandom_range(0, MAXR + 1);
      for (int k = 0; k <= MAXR; k++) begin
        r = $urandom;
        if (r == EXP_ID) r = ~r;
        att_id[k] = (k < fm) ? r : EXP_ID;
      end
      cur_ts = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      model(pass, dec, retry);
      do_reset();
      run(pass, dec, -1, dec + 2);
      check_status(att_id[retry], cur_ts,
                   {16'b0, 8'(retry), 5'b0, 1'b1, !pass, pass});
    end

    // Restart after pass, plus read-data hold between reads
    for (int k = 0; k <= MAXR; k++) att_id[k] = EXP_ID;
    cur_ts = EXP_TS;
    do_reset();
    run(1'b1, 3, -1, 5);
    rd(2'd2, d);
    chk("status before restart", d, 32'h0000_0005);
    @(negedge clock);
    chk("readdata held", avs_readdata, 32'h0000_0005);
    avs_write = 1'b1; avs_address = 2'd3; avs_writedata = 32'd1;
    @(negedge clock);
    avs_write = 1'b0;
    chk("restart sys_hold", {31'b0, sys_hold}, 32'd1);
    chk("restart id_ok", {31'b0, id_ok}, 32'd0);
    repeat (2) @(negedge clock);
    chk("restart id_ok R+2", {31'b0, id_ok}, 32'd0);
    @(negedge clock);
    chk("restart id_ok R+3", {31'b0, id_ok}, 32'd1);
    chk("restart sys_hold R+3", {31'b0, sys_hold}, 32'd0);

    // Restart write during WAIT must be ignored
    att_id[0] = 32'd5;
    for (int k = 1; k <= MAXR; k++) att_id[k] = EXP_ID;
    do_reset();
    run(1'b1, 22, 5, 24);
    rd(2'd2, d);
    chk("status after ignored restart", d, 32'h0000_0105);

    // Asynchronous reset in the middle of WAIT
    do_reset();
    run(1'b1, 22, -1, 10);
    rd(2'd0, d);
    chk("id_reg mid-wait", d, 32'd5);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async reset");
    for (int k = 0; k <= MAXR; k++) att_id[k] = EXP_ID;
    @(negedge clock);
    cur_id = att_id[0];
    reset_n = 1'b1;
    run(1'b1, 3, -1, 5);
    check_status(EXP_ID, EXP_TS, 32'h0000_0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
